instruction_fetch_unit: RTL

Instruction fetch stage of the MIPS core, directly upstream of the Control unit. Holds the PC, fetches instruction words from instruction memory over a req/ready handshake, and presents a registered instruction, its PC and its 6-bit opcode to decode. It handles wait-state memory, decode stalls through a one-entry skid buffer, and branch redirects and flushes.

---
 rtl/instruction_fetch_unit.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
`timescale 1ns/1ps
// ============================================================================
// instruction_fetch_unit
// ----------------------------------------------------------------------------
// Fetch stage of the MIPS core, directly upstream of the Control unit. Holds
// the PC, reads instruction words from instruction memory over a req/ready
// handshake, and presents a registered instruction, its PC and its opcode to
// decode. A one-entry skid buffer absorbs the word that is already on its
// way when decode stalls. Branch redirects and flushes invalidate everything
// fetched so far.
//
// Optional feature macro: IFU_ILLEGAL_OP_EN
//   defined     -> illegal_op flags a valid instruction whose opcode is not in
//                  the supported set {00,08,0c,0d,04,05,23,2b}
//   not defined -> illegal_op is tied to 0 and no opcode decode is built
//
// Memory handshake:
//   A read completes on any rising edge where imem_req && imem_ready.
//   Once imem_req rises it stays high, with imem_addr unchanged, until that
//   completion. A request is never withdrawn, even across a redirect. Data
//   that comes back for a redirected fetch is dropped in the DRAIN state.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   imem_req       read request to instruction memory
//   imem_addr      word-aligned read address (bits [1:0] always 0)
//   imem_ready     read completes when high together with imem_req
//   imem_rdata     instruction word, valid while imem_ready is high
//   stall          decode cannot accept: hold valid/instr_out/pc_out
//   flush          invalidate the output register and the skid buffer
//   branch_taken   redirect fetch to branch_target (also flushes)
//   branch_target  redirect address, bits [1:0] ignored
//   valid          instr_out/pc_out hold a live instruction
//   instr_out      fetched instruction
//   pc_out         address of instr_out
//   pc_plus4       pc_out + 4, modulo 2^32
//   opcode         instr_out[31:26], drives the Control unit OP input
//   illegal_op     unsupported-opcode flag (see macro above)
//   debugState     current fetch FSM state (0 = REQ, 1 = DRAIN)
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic        illegal_op,
    output logic        debugState
);

    // REQ   : normal fetching, request raised whenever the skid is empty
    // DRAIN : a redirect happened while a read was outstanding; that read is
    //         finished with its old address and its data thrown away
    typedef enum logic {
        REQ   = 1'b0,
        DRAIN = 1'b1
    } fetchStateT;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    fetchStateT  state;
    fetchStateT  stateNext;

    logic [31:0] pc;            // next sequential fetch address
    logic [31:0] pcNext;
    logic [31:0] drainAddr;     // address of the read being drained
    logic [31:0] drainAddrNext;

    logic        validNext;
    logic [31:0] instrNext;
    logic [31:0] pcOutNext;

    logic        skidValid;
    logic [31:0] skidInstr;
    logic [31:0] skidPc;
    logic        skidValidNext;
    logic [31:0] skidInstrNext;
    logic [31:0] skidPcNext;

    logic        reqRaw;
    logic [31:0] addrRaw;
    logic        fetchDone;
    logic        advance;
    logic [31:0] targetAligned;

    assign targetAligned = branch_target & ALIGN_MASK;

    // ------------------------------------------------------------------
    // Request generation. In REQ the request is suppressed while the skid
    // holds a word, because a stalled output plus a full skid has nowhere
    // to put another one. The skid can only fill on a completion, so this
    // never drops a request that is already up.
    // ------------------------------------------------------------------
    always_comb begin
        reqRaw  = 1'b0;
        addrRaw = pc;
        case (state)
            REQ: begin
                reqRaw  = !skidValid;
                addrRaw = pc;
            end
            DRAIN: begin
                reqRaw  = 1'b1;
                addrRaw = drainAddr;
            end
            default: begin
                reqRaw  = 1'b0;
                addrRaw = pc;
            end
        endcase
    end

    assign imem_req  = reqRaw && !reset;
    assign imem_addr = addrRaw & ALIGN_MASK;
    assign fetchDone = imem_req && imem_ready;
    assign advance   = valid && !stall;

    // ------------------------------------------------------------------
    // Next-state logic. Priority: branch_taken > flush > stall.
    // ------------------------------------------------------------------
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        drainAddrNext = drainAddr;
        validNext     = valid;
        instrNext     = instr_out;
        pcOutNext     = pc_out;
        skidValidNext = skidValid;
        skidInstrNext = skidInstr;
        skidPcNext    = skidPc;

        if (branch_taken) begin
            pcNext        = targetAligned;
            validNext     = 1'b0;
            skidValidNext = 1'b0;
            case (state)
                REQ: begin
                    // A read completing on this same edge is simply dropped;
                    // only a read still waiting needs the DRAIN detour.
                    if (imem_req && !imem_ready) begin
                        stateNext     = DRAIN;
                        drainAddrNext = addrRaw;
                    end
                end
                DRAIN: begin
                    // Only the target moves; the old read keeps draining.
                    if (fetchDone) begin
                        stateNext = REQ;
                    end
                end
                default: stateNext = REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (fetchDone) begin
                        pcNext = pc + 32'd4;
                    end
                    if (flush) begin
                        // Fetch position is kept, so the address stream
                        // carries on; only what is already captured dies.
                        validNext     = 1'b0;
                        skidValidNext = 1'b0;
                    end else if (advance) begin
                        if (skidValid) begin
                            instrNext     = skidInstr;
                            pcOutNext     = skidPc;
                            skidValidNext = 1'b0;
                        end else if (fetchDone) begin
                            instrNext = imem_rdata;
                            pcOutNext = addrRaw;
                        end else begin
                            validNext = 1'b0;
                        end
                    end else if (!valid) begin
                        if (fetchDone) begin
                            validNext = 1'b1;
                            instrNext = imem_rdata;
                            pcOutNext = addrRaw;
                        end
                    end else if (fetchDone) begin
                        // Output stalled: the word already on its way
                        // lands in the skid buffer.
                        skidValidNext = 1'b1;
                        skidInstrNext = imem_rdata;
                        skidPcNext    = addrRaw;
                    end
                end
                DRAIN: begin
                    // Output and skid were cleared by the redirect, so a
                    // flush has nothing left to do here.
                    if (fetchDone) begin
                        stateNext = REQ;
                    end
                end
                default: stateNext = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= PC_RESET & ALIGN_MASK;
            drainAddr <= PC_RESET & ALIGN_MASK;
            valid     <= 1'b0;
            instr_out <= 32'd0;
            pc_out    <= PC_RESET;
            skidValid <= 1'b0;
            skidInstr <= 32'd0;
            skidPc    <= 32'd0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            drainAddr <= drainAddrNext;
            valid     <= validNext;
            instr_out <= instrNext;
            pc_out    <= pcOutNext;
            skidValid <= skidValidNext;
            skidInstr <= skidInstrNext;
            skidPc    <= skidPcNext;
        end
    end

    assign pc_plus4   = pc_out + 32'd4;
    assign opcode     = instr_out[31:26];
    assign debugState = (state == DRAIN);

`ifdef IFU_ILLEGAL_OP_EN
    // Supported set: R-type, addi, ori, andi, beq, bne, lw, sw.
    always_comb begin
        illegal_op = 1'b0;
        if (valid) begin
            case (opcode)
                6'h00, 6'h08, 6'h0c, 6'h0d,
                6'h04, 6'h05, 6'h23, 6'h2b: illegal_op = 1'b0;
                default:                    illegal_op = 1'b1;
            endcase
        end
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule
